// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED colour fader
package led_pkg;

  localparam int COLOR_W_DEFAULT = 8;
  localparam int STEP_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_e;

  typedef struct packed {
    logic [COLOR_W_DEFAULT-1:0] r;
    logic [COLOR_W_DEFAULT-1:0] g;
    logic [COLOR_W_DEFAULT-1:0] b;
  } rgb_t;

  // A zero step would never finish a fade, so it is promoted to 1.
  function automatic logic [STEP_W-1:0] step_or_one(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

endpackage

// File: rtl/led_channel_ramp.sv
// rtl/led_channel_ramp.sv - one colour channel stepping toward its target
module led_channel_ramp
  import led_pkg::*;
#(
  parameter int COLOR_W = COLOR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               tick,
  input  logic [COLOR_W-1:0] tgt,
  input  logic [STEP_W-1:0]  step,
  output logic [COLOR_W-1:0] cur,
  output logic               at_target
);

  logic [COLOR_W-1:0] tgt_q;
  logic [STEP_W-1:0]  step_q;
  logic [COLOR_W:0]   up_gap;
  logic [COLOR_W:0]   dn_gap;
  logic [COLOR_W:0]   step_ext;
  logic [COLOR_W-1:0] cur_next;

  // Gaps are one bit wider so the clamp compare never wraps.
  always_comb begin
    up_gap   = {1'b0, tgt_q} - {1'b0, cur};
    dn_gap   = {1'b0, cur} - {1'b0, tgt_q};
    step_ext = (COLOR_W+1)'(step_q);
    cur_next = cur;
    if (cur < tgt_q) begin
      cur_next = (step_ext >= up_gap) ? tgt_q : cur + step_ext[COLOR_W-1:0];
    end else if (cur > tgt_q) begin
      cur_next = (step_ext >= dn_gap) ? tgt_q : cur - step_ext[COLOR_W-1:0];
    end
  end

  // at_target is cleared on load so a stale match from the previous fade cannot end this one early.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      tgt_q     <= '0;
      step_q    <= STEP_W'(1);
      at_target <= 1'b0;
    end else if (load) begin
      tgt_q     <= tgt;
      step_q    <= step;
      at_target <= 1'b0;
    end else begin
      if (tick) begin
        cur <= cur_next;
      end
      at_target <= (cur == tgt_q);
    end
  end

endmodule

// File: rtl/led_color_fader.sv
// rtl/led_color_fader.sv - linear RGB fader feeding the PWM duty inputs
module led_color_fader
  import led_pkg::*;
#(
  parameter int COLOR_W  = COLOR_W_DEFAULT,
  parameter int TICK_DIV = 50000,
  parameter int DIV_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] tgt_r,
  input  logic [COLOR_W-1:0] tgt_g,
  input  logic [COLOR_W-1:0] tgt_b,
  input  logic [STEP_W-1:0]  tgt_step,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               busy,
  output logic               done
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  fade_state_e       state;
  fade_state_e       state_next;
  logic [DIV_W-1:0]  tick_cnt;
  logic              tick;
  logic              load;
  logic              done_next;
  logic [STEP_W-1:0] step_eff;
  logic [2:0]        at;

  assign step_eff = step_or_one(tgt_step);
  assign tick     = (state == FADE) && (tick_cnt == TICK_LAST);
  assign busy     = (state == FADE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    tgt_ready  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          load       = 1'b1;
          state_next = FADE;
        end
      end
      FADE: begin
        if (&at) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (load) begin
        tick_cnt <= '0;
      end else if (state == FADE) begin
        tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
      end
    end
  end

  led_channel_ramp #(.COLOR_W(COLOR_W)) u_ramp_r (
    .clk(clk), .reset(reset), .load(load), .tick(tick),
    .tgt(tgt_r), .step(step_eff), .cur(R), .at_target(at[0])
  );

  led_channel_ramp #(.COLOR_W(COLOR_W)) u_ramp_g (
    .clk(clk), .reset(reset), .load(load), .tick(tick),
    .tgt(tgt_g), .step(step_eff), .cur(G), .at_target(at[1])
  );

  led_channel_ramp #(.COLOR_W(COLOR_W)) u_ramp_b (
    .clk(clk), .reset(reset), .load(load), .tick(tick),
    .tgt(tgt_b), .step(step_eff), .cur(B), .at_target(at[2])
  );

endmodule

// File: tb/tb_led_color_fader.sv
// tb/tb_led_color_fader.sv - scoreboard bench for led_color_fader
module tb_led_color_fader;
  import led_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tgt_r = '0, tgt_g = '0, tgt_b = '0;
  logic [3:0] tgt_step = '0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready, busy, done;
  logic [7:0] R, G, B;

  logic [7:0] b_tgt_r = '0, b_tgt_g = '0, b_tgt_b = '0;
  logic [3:0] b_tgt_step = '0;
  logic       b_tgt_valid = 1'b0;
  logic       b_tgt_ready, b_busy, b_done;
  logic [7:0] b_R, b_G, b_B;

  always #5 clk = ~clk;

  led_color_fader #(.COLOR_W(8), .TICK_DIV(TD), .DIV_W(24)) dut (
    .clk(clk), .reset(reset), .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .tgt_step(tgt_step), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .R(R), .G(G), .B(B), .busy(busy), .done(done)
  );

  led_color_fader #(.COLOR_W(8), .TICK_DIV(50000), .DIV_W(24)) dut_slow (
    .clk(clk), .reset(reset), .tgt_r(b_tgt_r), .tgt_g(b_tgt_g), .tgt_b(b_tgt_b),
    .tgt_step(b_tgt_step), .tgt_valid(b_tgt_valid), .tgt_ready(b_tgt_ready),
    .R(b_R), .G(b_G), .B(b_B), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    int sr, sg, sb;
    int tr, tg, tb;
    int st;
    int age;
  } item_t;

  item_t exp_q[$];
  int    cur_r = 0, cur_g = 0, cur_b = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Channel value after n ticks: straight-line approach, clamped at the target.
  function automatic int ramp(input int s, input int t, input int st, input int n);
    if (t >= s) return (s + n * st > t) ? t : s + n * st;
    return (s - n * st < t) ? t : s - n * st;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int fade_end(input item_t it);
    int d;
    d = absd(it.sr, it.tr);
    if (absd(it.sg, it.tg) > d) d = absd(it.sg, it.tg);
    if (absd(it.sb, it.tb) > d) d = absd(it.sb, it.tb);
    return ((d + it.st - 1) / it.st) * TD + 2;
  endfunction

  item_t mi;
  int    mm, mend, er, eg, eb, edone, ebusy;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      cur_r = 0; cur_g = 0; cur_b = 0;
      chk("reset_rgb", int'({R, G, B}), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ready", int'(tgt_ready), 1);
    end else begin
      er = cur_r; eg = cur_g; eb = cur_b; edone = 0; ebusy = 0; mend = -1;
      if (exp_q.size() > 0) begin
        mi = exp_q[0];
        mi.age++;
        exp_q[0] = mi;
        mm    = mi.age;
        mend  = fade_end(mi);
        er    = ramp(mi.sr, mi.tr, mi.st, mm / TD);
        eg    = ramp(mi.sg, mi.tg, mi.st, mm / TD);
        eb    = ramp(mi.sb, mi.tb, mi.st, mm / TD);
        edone = (mm == mend) ? 1 : 0;
        ebusy = (mm < mend) ? 1 : 0;
      end
      chk("r", int'(R), er);
      chk("g", int'(G), eg);
      chk("b", int'(B), eb);
      chk("done", int'(done), edone);
      chk("busy", int'(busy), ebusy);
      chk("ready", int'(tgt_ready), 1 - ebusy);
      if (exp_q.size() > 0 && mm >= mend) begin
        cur_r = mi.tr; cur_g = mi.tg; cur_b = mi.tb;
        exp_q.pop_front();
      end
    end
  end

  task automatic send(input int r, input int g, input int b, input int st);
    item_t it;
    int n = 0;
    @(negedge clk);
    while (!tgt_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!tgt_ready) chk("send_ready_timeout", int'(tgt_ready), 1);
    tgt_r = 8'(r); tgt_g = 8'(g); tgt_b = 8'(b); tgt_step = 4'(st);
    tgt_valid = 1'b1;
    @(posedge clk);
    it.sr = cur_r; it.sg = cur_g; it.sb = cur_b;
    it.tr = r; it.tg = g; it.tb = b;
    it.st = (st == 0) ? 1 : st;
    it.age = -1;
    exp_q.push_back(it);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    int bad;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send(10, 0, 255, 4);           wait_idle();
    send(255, 255, 255, 15);       wait_idle();
    send(0, 128, 0, 15);           wait_idle();
    send(0, 0, 0, 15);             wait_idle();
    send(3, 0, 0, 0);              wait_idle();

    // A request during a fade must be ignored; the scoreboard keeps tracking the original fade.
    send(50, 60, 70, 2);
    repeat (3) @(negedge clk);
    chk("ready_in_fade", int'(tgt_ready), 0);
    tgt_r = 8'd200; tgt_g = 8'd200; tgt_b = 8'd200; tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    wait_idle();
    send(50, 60, 70, 5);           wait_idle();

    send(200, 0, 0, 10);
    n = 0;
    while (R != 8'd100 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_100", int'(R), 100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      if (i % 2 == 0) wait_idle();
    end
    wait_idle();

    chk("slow_ready", int'(b_tgt_ready), 1);
    b_tgt_r = 8'd1; b_tgt_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_tgt_valid = 1'b0;
    bad = 0;
    for (int i = 1; i <= 50000; i++) begin
      @(posedge clk);
      #1;
      if (i < 50000 && b_R != 8'd0) bad++;
      if (i == 50000) chk("slow_r_at_tick", int'(b_R), 1);
    end
    chk("slow_r_early_changes", bad, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_color_fader.md
Name: led_color_fader

Overview:
- Upstream feeder for the three-channel LED PWM stage.
- Accepts a target RGB colour via a valid/ready handshake, then ramps its registered R/G/B outputs linearly toward that target at a programmable step per tick.
- Outputs connect directly to the PWM stage's R/G/B duty inputs. Switch inputs or a controller can then request smooth fades instead of hard colour jumps.

Parameters:
- COLOR_W, 8, bit width of each colour channel; matches the PWM duty width.
- TICK_DIV, 50000, clk cycles per ramp tick; must be ≥ 2.
- DIV_W, 24, width of the tick counter; must satisfy 2^DIV_W > TICK_DIV.

Ports:
- clk  in  1  fade clock; same clock as the PWM stage.
- reset  in  1  synchronous, active-high reset.
- tgt_r  in  COLOR_W  target red.
- tgt_g  in  COLOR_W  target green.
- tgt_b  in  COLOR_W  target blue.
- tgt_step  in  4  per-tick increment magnitude; 0 is treated as 1.
- tgt_valid  in  1  target request.
- tgt_ready  out  1  block can accept a target.
- R  out  COLOR_W  current red, to PWM.
- G  out  COLOR_W  current green, to PWM.
- B  out  COLOR_W  current blue, to PWM.
- busy  out  1  fade in progress.
- done  out  1  one-cycle pulse on fade completion.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: R=G=B=0, busy=0, done=0, tgt_ready=1, state IDLE, tick counter 0, latched target 0, latched step 1.
- Reset mid-fade takes effect at the next clk edge. It aborts the fade and applies all reset values; done is not asserted.
- States: IDLE, FADE.
- IDLE behaviour:
  - tgt_ready=1.
  - On a clk edge with tgt_valid=1, latch tgt_r/g/b and step (step = tgt_step, or 1 if tgt_step=0).
  - Clear the tick counter and go to FADE.
  - R/G/B do not change on the accept edge.
- FADE behaviour:
  - tgt_ready=0 and busy=1. tgt_valid is ignored; there is no queueing and no retarget.
  - The tick counter increments each cycle and wraps at TICK_DIV-1. A tick is the cycle where counter == TICK_DIV-1.
  - On a tick edge, each channel independently updates:
    - if cur < tgt: cur += min(step, tgt-cur)
    - if cur > tgt: cur -= min(step, cur-tgt)
    - if cur == tgt: cur is unchanged.
  - Differences are computed at COLOR_W+1 bits. Because of the clamp, no overshoot and no wrap-around is possible; 255 never steps to 0.
  - Completion check happens every cycle, tick or not. If all three channels equal their targets, the next edge goes to IDLE and sets done=1.
- done: high for exactly one cycle, the first IDLE cycle after completion; busy=0 and tgt_ready=1 in that cycle. A new target accepted in that same cycle is legal.
- Latency:
  - The first output change occurs at the TICK_DIV-th edge after the accept edge.
  - A target equal to the current colour gives: accept edge k, done high after edge k+2, with no tick consumed.
- Fade duration in ticks = ceil(max channel |Δ| / step).
- The outputs are registered and never glitch, so they are safe to feed the PWM compare directly.

Decomposition:
- Shared package led_pkg:
  - COLOR_W default constant
  - fade state enum {IDLE, FADE}
  - rgb_t struct of three COLOR_W channels
  - STEP_W = 4
- Sub-module led_channel_ramp, instantiated three times:
  - inputs: clk, reset, load, tick, tgt, step
  - outputs: cur, at_target
  - holds the saturating step-toward logic
- The top level holds the FSM, tick counter, handshake and done/busy generation.

Test Plan (TICK_DIV=4 unless noted):
- Reset → R=G=B=0, busy=0, done=0, tgt_ready=1. Assert reset mid-fade with R=100 → all outputs 0 and IDLE on the next edge, no done pulse.
- From 0, target (10,0,255) with step 4 → R goes 4,8,10 over ticks 1–3 then holds. B goes 4…252 at tick 63, then 255 at tick 64. done pulses once, about 64×4+2 cycles after accept. No output exceeds its target.
- From (255,255,255), target (0,128,0) with step 15 → B reaches 0 at tick 17 (last step clamped to 0, no wrap). G steps 240,225…,135 then 128 at tick 9 and stays. busy=1 throughout and done pulses once.
- tgt_step=0, target R=3 from 0 → R goes 1,2,3 on three consecutive ticks (treated as step 1).
- Pulse tgt_valid with (200,200,200) during an active fade → tgt_ready=0, request ignored, original fade completes unchanged. Then a target equal to the current colour → done after edge k+2, outputs stable.
- With TICK_DIV=50000, accept target R=1 → R stays 0 for 49999 cycles and becomes 1 at exactly the 50000th edge after accept.
